// File: rtl/mesi_isc_param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, thresholds, flush,
// sticky push/pop error flags and a resettable high-water mark.
module mesi_isc_param_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_SIZE       = 4,
    parameter int FIFO_SIZE_LOG2  = 2,
    parameter int ALMOST_FULL_TH  = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      err_clr_i,
    input  logic                      wr_i,
    input  logic                      rd_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [FIFO_SIZE_LOG2:0]   count_o,
    output logic                      status_empty_o,
    output logic                      status_full_o,
    output logic                      status_almost_full_o,
    output logic                      status_almost_empty_o,
    output logic                      err_overflow_o,
    output logic                      err_underflow_o,
    output logic [FIFO_SIZE_LOG2:0]   max_count_o
);

    localparam int PW = FIFO_SIZE_LOG2 + 1;
    localparam logic [PW-1:0] SIZE_C  = PW'(FIFO_SIZE);
    localparam logic [PW-1:0] AF_TH_C = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH_C = PW'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_reg [FIFO_SIZE];
    logic [PW-1:0]         ptr_wr_reg;
    logic [PW-1:0]         ptr_rd_reg;
    logic [PW-1:0]         max_count_reg;
    logic                  err_overflow_reg;
    logic                  err_underflow_reg;

    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic [PW-1:0] max_count_next;
    logic          empty;
    logic          full;
    logic          rd_ok;
    logic          wr_ok;
    logic          wr_en;

    // Wrap-bit pointers: the modulo difference is the exact occupancy.
    assign count = ptr_wr_reg - ptr_rd_reg;
    assign empty = (count == '0);
    assign full  = (count == SIZE_C);

    assign rd_ok = rd_i & ~empty;
    assign wr_ok = wr_i & (~full | rd_i);
    assign wr_en = wr_ok & ~flush_i;

    always_comb begin
        count_next = count;
        if (flush_i) begin
            count_next = '0;
        end else begin
            count_next = count + PW'(wr_ok) - PW'(rd_ok);
        end
    end

    always_comb begin
        max_count_next = max_count_reg;
        if (err_clr_i) begin
            max_count_next = count_next;
        end else if (count_next > max_count_reg) begin
            max_count_next = count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_wr_reg <= '0;
            ptr_rd_reg <= '0;
        end else if (flush_i) begin
            ptr_wr_reg <= '0;
            ptr_rd_reg <= '0;
        end else begin
            if (wr_ok) ptr_wr_reg <= ptr_wr_reg + 1'b1;
            if (rd_ok) ptr_rd_reg <= ptr_rd_reg + 1'b1;
        end
    end

    // Clearing wins over a same-cycle error; a flush cycle raises no errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_overflow_reg  <= 1'b0;
            err_underflow_reg <= 1'b0;
            max_count_reg     <= '0;
        end else begin
            max_count_reg <= max_count_next;
            if (err_clr_i) begin
                err_overflow_reg  <= 1'b0;
                err_underflow_reg <= 1'b0;
            end else if (!flush_i) begin
                if (wr_i && !wr_ok) err_overflow_reg  <= 1'b1;
                if (rd_i && !rd_ok) err_underflow_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_SIZE; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && ptr_wr_reg[FIFO_SIZE_LOG2-1:0] == FIFO_SIZE_LOG2'(gi)) begin
                    mem_reg[gi] <= data_i;
                end
            end
        end
    endgenerate

    assign data_o                = mem_reg[ptr_rd_reg[FIFO_SIZE_LOG2-1:0]];
    assign count_o               = count;
    assign status_empty_o        = empty;
    assign status_full_o         = full;
    assign status_almost_full_o  = (count >= AF_TH_C);
    assign status_almost_empty_o = (count <= AE_TH_C);
    assign err_overflow_o        = err_overflow_reg;
    assign err_underflow_o       = err_underflow_reg;
    assign max_count_o           = max_count_reg;

endmodule

// File: tb/tb_mesi_isc_param_fifo.sv
// Bench for mesi_isc_param_fifo: directed scenarios plus random traffic,
// all outputs compared against a queue-based reference model every cycle.
module tb_mesi_isc_param_fifo;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int LG = 2;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          err_clr_i;
    logic          wr_i;
    logic          rd_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic [LG:0]   count_o;
    logic          status_empty_o;
    logic          status_full_o;
    logic          status_almost_full_o;
    logic          status_almost_empty_o;
    logic          err_overflow_o;
    logic          err_underflow_o;
    logic [LG:0]   max_count_o;

    mesi_isc_param_fifo #(
        .DATA_WIDTH(DW), .FIFO_SIZE(N), .FIFO_SIZE_LOG2(LG),
        .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .err_clr_i(err_clr_i),
        .wr_i(wr_i), .rd_i(rd_i), .data_i(data_i), .data_o(data_o),
        .count_o(count_o), .status_empty_o(status_empty_o),
        .status_full_o(status_full_o), .status_almost_full_o(status_almost_full_o),
        .status_almost_empty_o(status_almost_empty_o),
        .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o),
        .max_count_o(max_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] model_q[$];
    bit            m_ovf;
    bit            m_unf;
    int            m_max;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        int sz;
        sz = model_q.size();
        chk("count", DW'(count_o), DW'(sz));
        chk("empty", DW'(status_empty_o), DW'(sz == 0));
        chk("full", DW'(status_full_o), DW'(sz == N));
        chk("almost_full", DW'(status_almost_full_o), DW'(sz >= AF));
        chk("almost_empty", DW'(status_almost_empty_o), DW'(sz <= AE));
        chk("overflow", DW'(err_overflow_o), DW'(m_ovf));
        chk("underflow", DW'(err_underflow_o), DW'(m_unf));
        chk("max_count", DW'(max_count_o), DW'(m_max));
        if (sz != 0) chk("data_o", data_o, model_q[0]);
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare every output 1 time unit later.
    task automatic step(input bit rst, input bit fl, input bit clr,
                        input bit wr, input bit rd, input logic [DW-1:0] d);
        bit full_m, empty_m, rd_ok, wr_ok;
        @(negedge clk);
        rst_n = ~rst; flush_i = fl; err_clr_i = clr; wr_i = wr; rd_i = rd; data_i = d;
        @(posedge clk);
        if (rst) begin
            model_q.delete(); m_ovf = 0; m_unf = 0; m_max = 0;
        end else if (fl) begin
            model_q.delete();
            if (clr) begin m_ovf = 0; m_unf = 0; m_max = 0; end
        end else begin
            full_m  = (model_q.size() == N);
            empty_m = (model_q.size() == 0);
            rd_ok   = rd && !empty_m;
            wr_ok   = wr && (!full_m || rd);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
            if (clr) begin
                m_ovf = 0; m_unf = 0; m_max = model_q.size();
            end else begin
                if (wr && !wr_ok) m_ovf = 1;
                if (rd && !rd_ok) m_unf = 1;
                if (model_q.size() > m_max) m_max = model_q.size();
            end
        end
        #1;
        chk_all();
    endtask

    task automatic push(input logic [DW-1:0] d); step(0, 0, 0, 1, 0, d); endtask
    task automatic pop();                         step(0, 0, 0, 0, 1, '0); endtask
    task automatic idle();                        step(0, 0, 0, 0, 0, '0); endtask

    initial begin
        rst_n = 1'b0; flush_i = 0; err_clr_i = 0; wr_i = 0; rd_i = 0; data_i = '0;
        vectors = 0; miscompares = 0;
        model_q.delete(); m_ovf = 0; m_unf = 0; m_max = 0;

        // 1. Reset, then fill/drain
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        chk("reset_data_o", data_o, '0);
        for (int i = 0; i < 4; i++) begin
            push(32'hA0 + i);
            chk("fill_count", DW'(count_o), DW'(i + 1));
        end
        chk("fill_af", DW'(status_almost_full_o), 1);
        chk("fill_full", DW'(status_full_o), 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", data_o, 32'hA0 + i);
            pop();
        end
        chk("drain_empty", DW'(status_empty_o), 1);

        // 2. Overflow
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        push(32'hFF);
        chk("ovf_flag", DW'(err_overflow_o), 1);
        chk("ovf_count", DW'(count_o), 4);
        step(0, 0, 1, 0, 0, '0);
        chk("ovf_clr", DW'(err_overflow_o), 0);

        // 3. Push+pop on full
        step(0, 0, 0, 1, 1, 32'hB0);
        chk("fullrw_count", DW'(count_o), 4);
        chk("fullrw_head", data_o, 32'hA1);
        for (int i = 0; i < 4; i++) pop();

        // 4. Push+pop on empty
        step(0, 0, 0, 1, 1, 32'h55);
        chk("emptyrw_unf", DW'(err_underflow_o), 1);
        chk("emptyrw_count", DW'(count_o), 1);
        chk("emptyrw_data", data_o, 32'h55);
        pop();

        // 5. Wrap-around, at most 2 in flight
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            if (model_q.size() == 2) step(0, 0, 0, 1, 1, $urandom);
            else push($urandom);
        end
        while (model_q.size() != 0) pop();
        chk("wrap_max", DW'(max_count_o), 2);

        // 6. Flush then reset
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) push(32'hC0 + i);
        step(0, 1, 0, 1, 0, 32'hEE);
        chk("flush_count", DW'(count_o), 0);
        chk("flush_ovf", DW'(err_overflow_o), 0);
        chk("flush_max", DW'(max_count_o), 3);
        push(32'hD0); push(32'hD1);
        step(1, 0, 0, 1, 1, 32'hDD);
        chk("rst_count", DW'(count_o), 0);
        chk("rst_max", DW'(max_count_o), 0);
        chk("rst_data_o", data_o, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
